// File: rtl/sha256_hex_tx_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_hex_tx_formatter
//  Description : Captures a 256-bit digest and streams it to a UART TX core
//                as 64 ASCII hex characters (MS nibble first), optional CR LF.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_hex_tx_formatter #(
    parameter bit APPEND_CRLF = 1'b1,
    parameter bit UPPERCASE   = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] hash_in,
    input  logic         hash_valid,
    input  logic         tx_busy,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

    localparam logic [6:0] C_LAST       = APPEND_CRLF ? 7'd65 : 7'd63;
    localparam logic [7:0] C_ALPHA_BASE = UPPERCASE ? 8'h41 : 8'h61;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_ARM    = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t         r_state;
    logic [255:0]   r_digest;
    logic [6:0]     r_index;
    logic [3:0]     w_nib;
    logic [7:0]     w_char;

    // The digest shifts left one nibble per issued character, so the next
    // nibble to print always sits in the top four bits.
    always_comb begin
        w_nib = r_digest[255:252];
        if (r_index == 7'd64) begin
            w_char = 8'h0D;
        end else if (r_index == 7'd65) begin
            w_char = 8'h0A;
        end else if (w_nib < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nib};
        end else begin
            w_char = C_ALPHA_BASE + {4'h0, w_nib} - 8'd10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_digest <= '0;
            r_index  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            overrun  <= hash_valid && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (hash_valid) begin
                        r_digest <= hash_in;
                        r_index  <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!tx_busy) begin
                        tx_data  <= w_char;
                        tx_start <= 1'b1;
                        r_digest <= {r_digest[251:0], 4'h0};
                        r_state  <= S_ARM;
                    end
                end
                // The core raises tx_busy one cycle after tx_start; skip that cycle.
                S_ARM: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        if (r_index == C_LAST) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_FINISH;
                        end else begin
                            r_index <= r_index + 7'd1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
